// File: rtl/y86_fetch_unit.sv
// Y86-64 instruction-fetch initiator.
// Holds the PC, drives the memory instruction port, waits out the RAM read
// latency, then decodes and presents one instruction over a valid/ready
// handshake.
//
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   iaddr    out 64     instruction address (the PC register)
//   instr    in  80     10 instruction bytes, byte at iaddr in instr[7:0]
//   i_ok     in  1      memory reports iaddr in range
//   f_valid  out 1      decoded instruction available
//   f_ready  in  1      downstream accepts current instruction
//   new_pc   in  64     next PC, sampled on accept
//   f_pc     out 64     PC of the presented instruction
//   icode/ifun/rA/rB    decoded fields
//   valC     out 64     constant word
//   valP     out 64     fall-through PC
//   stat     out 3      1 AOK, 2 HLT, 3 ADR, 4 INS
//   halted   out 1      fetch stopped until reset
module y86_fetch_unit #(
  parameter logic [63:0] PC_RESET    = 64'h0,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [63:0] iaddr,
  input  logic [79:0] instr,
  input  logic        i_ok,
  output logic        f_valid,
  input  logic        f_ready,
  input  logic [63:0] new_pc,
  output logic [63:0] f_pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic        halted
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pc_q, pc_d;
  logic             f_valid_q, f_valid_d;
  logic             halted_q, halted_d;
  logic [2:0]       stat_q, stat_d;
  logic [63:0]      f_pc_q, f_pc_d;
  logic [3:0]       icode_q, icode_d;
  logic [3:0]       ifun_q, ifun_d;
  logic [3:0]       ra_q, ra_d;
  logic [3:0]       rb_q, rb_d;
  logic [63:0]      valc_q, valc_d;
  logic [63:0]      valp_q, valp_d;

  logic [3:0]  icode_c, ifun_c, ra_c, rb_c;
  logic [63:0] valc_c, valp_c;
  logic        need_regids_c, need_valc_c, instr_valid_c;
  logic [2:0]  stat_c;

  // Combinational decode of the word currently returned by memory.
  always_comb begin
    icode_c       = instr[7:4];
    ifun_c        = instr[3:0];
    need_regids_c = 1'b0;
    need_valc_c   = 1'b0;
    instr_valid_c = 1'b0;

    case (icode_c)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids_c = 1'b1;
      default:                                  need_regids_c = 1'b0;
    endcase

    case (icode_c)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc_c = 1'b1;
      default:                      need_valc_c = 1'b0;
    endcase

    // Only cmovXX/jXX (0..6) and OPq (0..3) carry a function code.
    case (icode_c)
      4'h2, 4'h7: instr_valid_c = (ifun_c <= 4'd6);
      4'h6:       instr_valid_c = (ifun_c <= 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                  instr_valid_c = (ifun_c == 4'd0);
      default:    instr_valid_c = 1'b0;
    endcase

    if (need_regids_c) begin
      ra_c   = instr[15:12];
      rb_c   = instr[11:8];
      valc_c = instr[79:16];
    end else begin
      ra_c   = 4'hF;
      rb_c   = 4'hF;
      valc_c = instr[71:8];
    end

    valp_c = pc_q + 64'd1 + 64'(need_regids_c) + (need_valc_c ? 64'd8 : 64'd0);

    // Address fault outranks decode faults, which outrank halt.
    if (!i_ok)               stat_c = STAT_ADR;
    else if (!instr_valid_c) stat_c = STAT_INS;
    else if (icode_c == 4'h0) stat_c = STAT_HLT;
    else                     stat_c = STAT_AOK;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    f_valid_d = f_valid_q;
    halted_d  = halted_q;
    stat_d    = stat_q;
    f_pc_d    = f_pc_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    valc_d    = valc_q;
    valp_d    = valp_q;

    case (state_q)
      ST_FETCH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          f_valid_d = 1'b1;
          stat_d    = stat_c;
          f_pc_d    = pc_q;
          icode_d   = icode_c;
          ifun_d    = ifun_c;
          ra_d      = ra_c;
          rb_d      = rb_c;
          valc_d    = valc_c;
          valp_d    = valp_c;
          state_d   = ST_VALID;
        end
      end
      ST_VALID: begin
        if (f_ready) begin
          f_valid_d = 1'b0;
          if (stat_q == STAT_AOK) begin
            pc_d    = new_pc;
            cnt_d   = CNT_INIT;
            state_d = ST_FETCH;
          end else begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        f_valid_d = 1'b0;
        halted_d  = 1'b1;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      cnt_q     <= CNT_INIT;
      pc_q      <= PC_RESET;
      f_valid_q <= 1'b0;
      halted_q  <= 1'b0;
      stat_q    <= STAT_AOK;
      f_pc_q    <= '0;
      icode_q   <= '0;
      ifun_q    <= '0;
      ra_q      <= 4'hF;
      rb_q      <= 4'hF;
      valc_q    <= '0;
      valp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      f_valid_q <= f_valid_d;
      halted_q  <= halted_d;
      stat_q    <= stat_d;
      f_pc_q    <= f_pc_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      valc_q    <= valc_d;
      valp_q    <= valp_d;
    end
  end

  assign iaddr   = pc_q;
  assign f_valid = f_valid_q;
  assign halted  = halted_q;
  assign stat    = stat_q;
  assign f_pc    = f_pc_q;
  assign icode   = icode_q;
  assign ifun    = ifun_q;
  assign rA      = ra_q;
  assign rB      = rb_q;
  assign valC    = valc_q;
  assign valP    = valp_q;

endmodule
